imm_extend_seq: RTL and testbench



---
 rtl/imm_extend_seq_pkg.sv | 23 ++
 rtl/imm_extend_seq_ror_step.sv | 13 +
 rtl/imm_extend_seq.sv | 118 +++++++++++
 tb/tb_imm_extend_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_seq_pkg.sv
// Shared types and the 32-bit rotate helper for the sequential immediate extender.
// Immediate-source encodings and controller states live here so decode and datapath agree.
package extend_pkg;

    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_HALF = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    // A zero amount leaves v unchanged: the left shift by 32 contributes nothing.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/imm_extend_seq_ror_step.sv
// One combinational rotate chunk: rotates a 32-bit value right by 2*k bits.
// k never exceeds 15 because it is bounded by the 4-bit remaining-step count.
module imm_ror_step
    import extend_pkg::*;
(
    input  logic [31:0] value_i,
    input  logic [3:0]  k_i,
    output logic [31:0] value_o
);

    assign value_o = ror32(value_i, {k_i, 1'b0});

endmodule

// File: rtl/imm_extend_seq.sv
// Handshaked immediate extender: decodes the instruction immediate per ImmSrc and
// performs the data-processing rotation iteratively, STEPS_PER_CYCLE 2-bit steps per cycle.
module imm_extend_seq
    import extend_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [23:0]     Instruction,
    input  logic [1:0]      ImmSrc,
    input  logic            carry_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ExtImm,
    output logic            carry_out,
    output logic            busy
);

    localparam logic [4:0] STEP_AMT = 5'(STEPS_PER_CYCLE);

    state_t          state_q;
    logic [31:0]     val_q;
    logic [3:0]      rem_q;
    logic [XLEN-1:0] ext_q;
    logic            carry_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [3:0]      k_d;
    logic [3:0]      rem_d;
    logic [31:0]     val_d;

    // Chunk size is min(rem, STEPS_PER_CYCLE); when rem is larger the step count is <= 14.
    always_comb begin
        k_d = rem_q;
        if ({1'b0, rem_q} > STEP_AMT) begin
            k_d = STEP_AMT[3:0];
        end
        rem_d = rem_q - k_d;
    end

    imm_ror_step u_step (
        .value_i (val_q),
        .k_i     (k_d),
        .value_o (val_d)
    );

    assign in_ready  = !reset && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign ExtImm    = ext_q;
    assign carry_out = carry_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            val_q       <= '0;
            rem_q       <= '0;
            ext_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        carry_q     <= carry_in;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        case (ImmSrc)
                            IMM_DP: begin
                                ext_q <= XLEN'(Instruction[7:0]);
                                if (Instruction[11:8] != 4'd0) begin
                                    val_q       <= {24'd0, Instruction[7:0]};
                                    rem_q       <= Instruction[11:8];
                                    state_q     <= ROTATE;
                                    out_valid_q <= 1'b0;
                                end
                            end
                            IMM_MEM:  ext_q <= XLEN'(Instruction[11:0]);
                            IMM_BR:   ext_q <= XLEN'($signed({Instruction, 2'b00}));
                            IMM_HALF: ext_q <= XLEN'({Instruction[11:8], Instruction[3:0]});
                            default:  ext_q <= '0;
                        endcase
                    end
                end
                ROTATE: begin
                    val_q <= val_d;
                    rem_q <= rem_d;
                    if (rem_d == 4'd0) begin
                        ext_q       <= XLEN'(val_d);
                        carry_q     <= val_d[31];
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_seq.sv
// Scoreboard bench for imm_extend_seq with three configurations:
// (XLEN=32,STEPS=1), (XLEN=64,STEPS=4), (XLEN=32,STEPS=16).
module tb_imm_extend_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] Instruction;
    logic [1:0]  ImmSrc;
    logic        carry_in;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  carry_out;
    wire  [2:0]  busy;
    wire  [31:0] ext0;
    wire  [63:0] ext1;
    wire  [31:0] ext2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] ext;
        logic        c;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    imm_extend_seq #(.XLEN(32), .STEPS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Instruction(Instruction), .ImmSrc(ImmSrc), .carry_in(carry_in),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .ExtImm(ext0),
        .carry_out(carry_out[0]), .busy(busy[0])
    );

    imm_extend_seq #(.XLEN(64), .STEPS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Instruction(Instruction), .ImmSrc(ImmSrc), .carry_in(carry_in),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .ExtImm(ext1),
        .carry_out(carry_out[1]), .busy(busy[1])
    );

    imm_extend_seq #(.XLEN(32), .STEPS_PER_CYCLE(16)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .Instruction(Instruction), .ImmSrc(ImmSrc), .carry_in(carry_in),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .ExtImm(ext2),
        .carry_out(carry_out[2]), .busy(busy[2])
    );

    function automatic logic [63:0] ext_of(input int d);
        case (d)
            0:       return {32'd0, ext0};
            1:       return ext1;
            default: return {32'd0, ext2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Independent reference for the DP-rotate path.
    function automatic logic [31:0] model_ror(input logic [31:0] v, input int sh);
        logic [63:0] t;
        t = {v, v} >> sh;
        return t[31:0];
    endfunction

    task automatic do_req(input string tag, input int d, input logic [23:0] ins,
                          input logic [1:0] src, input logic c,
                          input logic [63:0] ee, input logic ec, input int el);
        exp_t e;
        exp_t got_e;
        int   n;
        int   lat;
        e.ext = ee; e.c = ec; e.lat = el;
        sbq.push_back(e);
        @(negedge clk);
        Instruction = ins; ImmSrc = src; carry_in = c; in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            check({tag, "_accept"}, 64'(in_ready[d]), 64'd1);
            in_valid[d] = 1'b0;
            void'(sbq.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must have captured them already.
        in_valid[d] = 1'b0;
        Instruction = ~ins; ImmSrc = ~src; carry_in = ~c;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid[d]) break;
        end
        got_e = sbq.pop_front();
        check({tag, "_lat"},   64'(lat), 64'(got_e.lat));
        check({tag, "_ext"},   ext_of(d), got_e.ext);
        check({tag, "_carry"}, 64'(carry_out[d]), 64'(got_e.c));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] rins;
        logic [31:0] rexp;
        int          rot;
        int          seen;

        reset = 1'b1; in_valid = '0; out_ready = 3'b111;
        Instruction = '0; ImmSrc = '0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ext0",      ext_of(0), 64'd0);
        check("rst_ext1",      ext_of(1), 64'd0);
        check("rst_carry",     64'(carry_out), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'h7);

        do_req("dp_norot_c0", 0, 24'h0000FF, 2'b00, 1'b0, 64'h0000_00FF, 1'b0, 1);
        do_req("dp_norot_c1", 0, 24'h0000FF, 2'b00, 1'b1, 64'h0000_00FF, 1'b1, 1);
        do_req("dp_4ff_s1",   0, 24'h0004FF, 2'b00, 1'b0, 64'hFF00_0000, 1'b1, 5);
        do_req("dp_103_s1",   0, 24'h000103, 2'b00, 1'b0, 64'hC000_0000, 1'b1, 2);
        do_req("dp_f01_s1",   0, 24'h000F01, 2'b00, 1'b1, 64'h0000_0004, 1'b0, 16);
        do_req("br_neg",      0, 24'hFFFFFE, 2'b10, 1'b1, 64'hFFFF_FFF8, 1'b1, 1);
        do_req("br_pos",      0, 24'h000001, 2'b10, 1'b0, 64'h0000_0004, 1'b0, 1);
        do_req("mem12",       0, 24'hABCFFF, 2'b01, 1'b1, 64'h0000_0FFF, 1'b1, 1);
        do_req("half8",       0, 24'hFFFA75, 2'b11, 1'b0, 64'h0000_00A5, 1'b0, 1);

        do_req("br_neg_x64",  1, 24'hFFFFFE, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1);
        do_req("dp_f01_s4",   1, 24'h000F01, 2'b00, 1'b0, 64'h0000_0004, 1'b0, 5);
        do_req("dp_4ff_s4",   1, 24'h0004FF, 2'b00, 1'b0, 64'hFF00_0000, 1'b1, 2);
        do_req("dp_4ff_s16",  2, 24'h0004FF, 2'b00, 1'b0, 64'hFF00_0000, 1'b1, 2);
        do_req("dp_f01_s16",  2, 24'h000F01, 2'b00, 1'b1, 64'h0000_0004, 1'b0, 2);

        for (int i = 0; i < 8; i++) begin
            rins = 24'($urandom);
            rot  = int'(rins[11:8]);
            rexp = model_ror({24'd0, rins[7:0]}, 2 * rot);
            do_req("dp_rand_s4", 1, rins, 2'b00, rins[20],
                   {32'd0, rexp}, (rot == 0) ? rins[20] : rexp[31],
                   (rot == 0) ? 1 : 1 + (rot + 3) / 4);
        end

        // Backpressure: result held in DONE, new request waits for the handshake.
        @(negedge clk);
        out_ready[0] = 1'b0;
        Instruction = 24'h000123; ImmSrc = 2'b01; carry_in = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        Instruction = 24'h000456;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check("bp_ext_hold",  ext_of(0), 64'h123);
            check("bp_in_ready",  64'(in_ready[0]), 64'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", 64'(out_valid[0]), 64'd0);
        check("bp_after_hs_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 64'(out_valid[0]), 64'd1);
        check("bp_next_ext",   ext_of(0), 64'h456);
        @(posedge clk);
        #1;

        // Reset during ROTATE aborts the operation.
        @(negedge clk);
        Instruction = 24'h0008FF; ImmSrc = 2'b00; carry_in = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rot_busy",       64'(busy[0]), 64'd1);
        check("rot_no_valid",   64'(out_valid[0]), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid[0]), 64'd0);
        check("abort_ext",       ext_of(0), 64'd0);
        check("abort_busy",      64'(busy[0]), 64'd0);
        check("abort_in_ready",  64'(in_ready[0]), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        check("abort_idle_ready", 64'(in_ready[0]), 64'd1);
        do_req("dp_8ff_after", 0, 24'h0008FF, 2'b00, 1'b1, 64'h00FF_0000, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
